// File: rtl/weight_skew_feeder_pkg.sv
// weight_skew_feeder_pkg: shared sizing defaults, FSM encoding and lane slicing
// for the skewed weight feeder.
package weight_skew_feeder_pkg;
    localparam int WSF_DW         = 16;
    localparam int WSF_NUM_BRAMS  = 16;
    localparam int WSF_ADDR_WIDTH = 11;
    localparam int WSF_RD_LATENCY = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FILL   = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic logic [WSF_DW-1:0] lane(input logic [WSF_NUM_BRAMS*WSF_DW-1:0] flat, input int k);
        return flat[k*WSF_DW +: WSF_DW];
    endfunction
endpackage

// File: rtl/weight_skew_feeder_skew_delay_line.sv
// skew_delay_line: DELAY-stage register chain with a parallel valid bit;
// DELAY=0 passes the input straight through.
module skew_delay_line #(
    parameter int DW    = 16,
    parameter int DELAY = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] d,
    input  logic          v,
    output logic [DW-1:0] q,
    output logic          qv
);
    if (DELAY == 0) begin : g_pass
        logic unused_clk;
        assign unused_clk = &{1'b0, clk, rst_n};
        assign q  = d;
        assign qv = v;
    end else begin : g_chain
        logic [DELAY-1:0][DW-1:0] data;
        logic [DELAY-1:0]         valid;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data  <= '0;
                valid <= '0;
            end else begin
                data[0]  <= d;
                valid[0] <= v;
                for (int i = 1; i < DELAY; i++) begin
                    data[i]  <= data[i-1];
                    valid[i] <= valid[i-1];
                end
            end
        end
        assign q  = data[DELAY-1];
        assign qv = valid[DELAY-1];
    end
endmodule

// File: rtl/weight_skew_feeder.sv
// weight_skew_feeder: launches one BRAM transpose burst, captures its words and
// emits them diagonally skewed (lane k delayed k cycles) to the PE array.
module weight_skew_feeder
    import weight_skew_feeder_pkg::*;
#(
    parameter int DW         = WSF_DW,
    parameter int NUM_BRAMS  = WSF_NUM_BRAMS,
    parameter int ADDR_WIDTH = WSF_ADDR_WIDTH,
    parameter int RD_LATENCY = WSF_RD_LATENCY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   addr_start,
    input  logic [ADDR_WIDTH-1:0]   addr_end,
    output logic                    trans_start,
    output logic [ADDR_WIDTH-1:0]   trans_addr_start,
    output logic [ADDR_WIDTH-1:0]   trans_addr_end,
    input  logic                    trans_done,
    input  logic [NUM_BRAMS*DW-1:0] weight_in_flat,
    output logic [NUM_BRAMS*DW-1:0] skew_out_flat,
    output logic [NUM_BRAMS-1:0]    skew_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam int CW  = ADDR_WIDTH + 1;
    localparam int LW  = $clog2(RD_LATENCY + 1);
    localparam int DCW = $clog2(NUM_BRAMS + 1);

    state_t                  state, state_nx;
    logic [CW-1:0]           n_words, wcnt;
    logic [LW-1:0]           lat;
    logic [DCW-1:0]          dcnt;
    logic                    seen, cap, last, bad;
    logic [NUM_BRAMS*DW-1:0] st0_data;
    logic                    st0_valid;

    // The word present in the WAIT cycle whose latency count hits 0 is word 0.
    assign cap         = (state == WAIT && lat == '0) || state == FILL;
    assign last        = cap && wcnt == n_words - 1'b1;
    assign bad         = trans_addr_end < trans_addr_start;
    assign trans_start = state == LAUNCH && !bad;
    assign busy        = state != IDLE;
    assign done        = state == DONE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? LAUNCH : IDLE;
            LAUNCH:  state_nx = bad ? DONE : WAIT;
            WAIT:    state_nx = lat != '0 ? WAIT : last ? DRAIN : FILL;
            FILL:    state_nx = last ? DRAIN : FILL;
            DRAIN:   state_nx = dcnt == '0 ? DONE : DRAIN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            trans_addr_start <= '0;
            trans_addr_end   <= '0;
            n_words          <= '0;
            wcnt             <= '0;
            lat              <= '0;
            dcnt             <= '0;
            seen             <= 1'b0;
            err              <= 1'b0;
            st0_data         <= '0;
            st0_valid        <= 1'b0;
        end else begin
            state     <= state_nx;
            lat       <= state == WAIT ? lat - 1'b1 : LW'(RD_LATENCY - 1);
            dcnt      <= state == DRAIN ? dcnt - 1'b1 : DCW'(NUM_BRAMS - 1);
            wcnt      <= state == IDLE ? '0 : wcnt + CW'(cap);
            seen      <= state == IDLE ? 1'b0 : seen | trans_done;
            st0_data  <= cap ? weight_in_flat : '0;
            st0_valid <= cap;
            if (state == IDLE && start) begin
                trans_addr_start <= addr_start;
                trans_addr_end   <= addr_end;
                n_words          <= {1'b0, addr_end} - {1'b0, addr_start} + 1'b1;
                err              <= 1'b0;
            end else if ((state == LAUNCH && bad) ||
                         (state == FILL && trans_done && wcnt < n_words - 1'b1) ||
                         (state == DRAIN && dcnt == '0 && !seen && !trans_done)) begin
                err <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NUM_BRAMS; k++) begin : g_lane
        skew_delay_line #(.DW(DW), .DELAY(k)) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (st0_data[k*DW +: DW]),
            .v     (st0_valid),
            .q     (skew_out_flat[k*DW +: DW]),
            .qv    (skew_valid[k])
        );
    end
endmodule

// File: tb/tb_weight_skew_feeder.sv
// tb_weight_skew_feeder: directed and randomized bursts through the feeder, every
// output checked each cycle against a burst-level timing model.
module tb_weight_skew_feeder;
    localparam int DW = 16, NB = 16, AW = 11;
    localparam int NORMAL = 0, NONE = 1, EARLY = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, trans_done = 1'b0;
    logic trans_start, busy, done, err;
    logic [AW-1:0] addr_start = '0, addr_end = '0, trans_addr_start, trans_addr_end;
    logic [NB*DW-1:0] weight_in_flat = '0, skew_out_flat;
    logic [NB-1:0] skew_valid;

    int total = 0, bad = 0, t = 0;
    int bs = 0, brow = 0, bn = 0, bmode = 0, err_from = -1, td_mode = 0;
    logic bbad = 1'b0, active = 1'b0;
    logic [DW-1:0] salt = '0;
    logic [AW-1:0] ea_s = '0, ea_e = '0;

    always #5 clk = ~clk;

    weight_skew_feeder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .addr_start       (addr_start),
        .addr_end         (addr_end),
        .trans_start      (trans_start),
        .trans_addr_start (trans_addr_start),
        .trans_addr_end   (trans_addr_end),
        .trans_done       (trans_done),
        .weight_in_flat   (weight_in_flat),
        .skew_out_flat    (skew_out_flat),
        .skew_valid       (skew_valid),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // Burst length in cycles from the accepting start to DONE.
    function automatic int span();
        return bbad ? 2 : bn + 19;
    endfunction

    function automatic logic [DW-1:0] word(input int j, input int k);
        return DW'(((brow + j) % 2048) * 16 + k) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic check();
        logic [NB*DW-1:0] eo;
        logic [NB-1:0] ev;
        int d, j;
        d = t - bs;
        eo = '0;
        ev = '0;
        for (int k = 0; k < NB; k++) begin
            j = d - 4 - k;
            if (active && !bbad && j >= 0 && j < bn) begin
                ev[k] = 1'b1;
                eo[k*DW +: DW] = word(j, k);
            end
        end
        chk("skew_out", skew_out_flat, eo);
        chk("skew_valid", skew_valid, ev);
        chk("busy", busy, active && d >= 1 && d <= span());
        chk("done", done, active && d == span());
        chk("trans_start", trans_start, active && d == 1 && !bbad);
        chk("err", err, err_from >= 0 && t >= err_from);
        chk("trans_addr_start", trans_addr_start, ea_s);
        chk("trans_addr_end", trans_addr_end, ea_e);
    endtask

    task automatic cycle(input logic st, input int as, input int ae);
        int d, j;
        d = t - bs;
        j = d - 3;
        start = st;
        addr_start = AW'(as);
        addr_end = AW'(ae);
        trans_done = 1'b0;
        for (int k = 0; k < NB; k++) weight_in_flat[k*DW +: DW] = DW'($urandom);
        if (active && !bbad && j >= 0 && j < bn) begin
            for (int k = 0; k < NB; k++) weight_in_flat[k*DW +: DW] = word(j, k);
            trans_done = (bmode == NORMAL && j == bn - 1) || (bmode == EARLY && j == 1);
        end
        if (st && rst_n && !(active && d >= 1 && d <= span())) begin
            bs = t;
            brow = as;
            bn = ae - as + 1;
            bbad = ae < as;
            bmode = td_mode;
            salt = DW'($urandom);
            active = 1'b1;
            ea_s = AW'(as);
            ea_e = AW'(ae);
            err_from = bbad ? t + 2 : bmode == NONE ? t + span() : bmode == EARLY ? t + 5 : -1;
        end
        @(posedge clk);
        #1;
        t++;
        check();
    endtask

    // poke: 1 re-pulses start mid-FILL, 2 asserts reset mid-FILL.
    task automatic run_burst(input int as, input int ae, input int mode, input int poke);
        td_mode = mode;
        cycle(1'b1, as, ae);
        while (active && t - bs <= span()) begin
            if (poke == 1 && t - bs == 6) cycle(1'b1, as + 100, ae + 100);
            else if (poke == 2 && t - bs == 7) begin
                #2 rst_n = 1'b0;
                #1;
                active = 1'b0;
                err_from = -1;
                ea_s = '0;
                ea_e = '0;
                check();
                cycle(1'b0, 0, 0);
                rst_n = 1'b1;
            end else cycle(1'b0, 0, 0);
        end
        cycle(1'b0, 0, 0);
    endtask

    initial begin
        repeat (2) cycle(1'b0, 0, 0);
        rst_n = 1'b1;
        cycle(1'b0, 0, 0);
        run_burst(0, 3, NORMAL, 0);
        run_burst(5, 5, NORMAL, 0);
        run_burst(7, 2, NORMAL, 0);
        run_burst(20, 25, NORMAL, 1);
        run_burst(0, 9, NORMAL, 2);
        run_burst(0, 3, NORMAL, 0);
        run_burst(40, 44, EARLY, 0);
        run_burst(1, 1, NONE, 0);
        for (int i = 0; i < 6; i++) begin
            int a, n;
            a = int'($urandom_range(0, 2000));
            n = int'($urandom_range(1, 40));
            run_burst(a, a + n - 1, NORMAL, 0);
            repeat ($urandom_range(0, 3)) cycle(1'b0, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
        end
        run_burst(0, 2047, NONE, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
